cva6_uncached_wr_arbiter: RTL and testbench
===========================================

// Module: cva6_uncached_wr_arbiter
// PURPOSE
// - Shares one single-beat AXI4 write path (AW+W+B) between NumReq CVA6 uncached/non-idempotent store ports.
// - Round-robin arbitration; prepends the requester index to the AXI ID; routes B responses back by that index.
// - Caps in-flight writes at MaxOutstanding (CVA6 cluster uses 7). Sits between the cores and the SoC crossbar slave port.
// PARAMETERS
// - NumReq          2     number of requesters (>=2)
// - AddrWidth       64    AXI address width
// - DataWidth       64    AXI data width; strobe width is DataWidth/8
// - InIdWidth       4     requester ID width (CVA6 fixed at 4)
// - OutIdWidth      InIdWidth+$clog2(NumReq)   downstream ID width; index occupies the MSBs
// - MaxOutstanding  7     max un-responded writes (1..255)
// - TimeoutCycles   1024  watchdog limit (used only with UNCACHED_WR_TIMEOUT_EN)
// PORTS
// - clk_i          in   1                 clock
// - rst_i          in   1                 synchronous reset, active-high
// - req_valid_i    in   NumReq            write request valid per requester
// - req_ready_o    out  NumReq            request accepted (one-cycle pulse to the granted requester)
// - req_addr_i     in   NumReq*AddrWidth  address
// - req_data_i     in   NumReq*DataWidth  write data
// - req_strb_i     in   NumReq*DataWidth/8  byte strobes
// - req_id_i       in   NumReq*InIdWidth  requester-local ID
// - rsp_valid_o    out  NumReq            write response valid
// - rsp_ready_i    in   NumReq            write response accepted
// - rsp_resp_o     out  2                 BRESP (shared; qualified by rsp_valid_o)
// - rsp_id_o       out  InIdWidth         requester-local ID (index bits stripped)
// - aw_valid_o/aw_ready_i  out/in 1       AW handshake; aw_addr_o AddrWidth, aw_id_o OutIdWidth
// - w_valid_o/w_ready_i    out/in 1       W handshake; w_data_o DataWidth, w_strb_o DataWidth/8, w_last_o 1 (always 1)
// - b_valid_i/b_ready_o    in/out 1       B handshake; b_id_i OutIdWidth, b_resp_i 2
// - outstanding_o  out  8                 current in-flight count
// - timeout_o      out  1                 sticky watchdog flag
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer=0, count=0, all valid/ready outputs 0, data outputs 0, timeout_o 0.
// - FSM IDLE: if any req_valid_i and count<MaxOutstanding: pick first valid index at/after (last_grant+1) mod NumReq;
//   pulse req_ready_o[idx] that cycle, latch payload, ID={idx,req_id}, count++, last_grant=idx, go SEND.
// - count==MaxOutstanding: no grant, even if a B handshake occurs the same cycle (grant possible next cycle).
// - SEND: aw_valid_o and w_valid_o both asserted from the cycle after grant; each deasserts after its own handshake;
//   AW and W may complete in either order or together. Both done -> IDLE next cycle. Min req-to-req spacing 2 cycles.
// - Payload on aw_*/w_* stable while the respective valid is high (AXI rule); no valid withdrawn before ready.
// - B path combinational: idx=b_id_i MSBs; rsp_valid_o[idx]=b_valid_i; b_ready_o=rsp_ready_i[idx];
//   rsp_id_o/rsp_resp_o = b_id_i LSBs/b_resp_i.
// - idx>=NumReq (illegal): b_ready_o=1, response dropped, no rsp_valid_o.
// - B handshake: count--. Grant and B same cycle: count unchanged. B with count==0: count stays 0 (no underflow).
// - rst_i mid-SEND: transaction abandoned, outputs return to reset values next cycle; no replay.
// CONFIGURATION
// - UNCACHED_WR_TIMEOUT_EN defined: cycle counter runs while count>0 and no B handshake; cleared on B handshake or count==0;
//   on reaching TimeoutCycles-1, timeout_o sets and holds until rst_i. Flow control unaffected.
// - Not defined: no counter logic; timeout_o tied 0.
// TESTING
// - Single req0 addr=0x1A10_0000 data=0xDEAD_BEEF id=3, ready tied high -> aw_valid at +1 cycle, aw_id=0x03, B resp=0 -> rsp_valid_o[0], rsp_id_o=3.
// - req0 and req1 valid continuously, NumReq=2 -> grants alternate 0,1,0,1; aw_id MSB toggles; each requester gets 50%.
// - aw_ready_i=0 for 5 cycles, w_ready_i=1 -> W completes first, AW held stable, FSM stays SEND until AW handshake.
// - 7 grants with b_valid_i=0 -> outstanding_o=7, req_ready_o stays 0; one B -> next grant one cycle later, outstanding back to 7.
// - Same-cycle grant and B at count=3 -> count stays 3; B with b_id MSB index=NumReq (NumReq=3) -> dropped, b_ready_o=1.
// - UNCACHED_WR_TIMEOUT_EN, TimeoutCycles=16, one write, no B -> timeout_o=1 after 15 cycles, stays set after late B.

Source files
------------

// File: rtl/cva6_uncached_wr_arbiter.sv
// cva6_uncached_wr_arbiter
//
// Purpose: shares one single-beat AXI4 write path (AW + W + B) between NumReq
// uncached / non-idempotent store ports. Requests are granted round-robin, one
// at a time. The requester index is prepended to the AXI ID, and B responses
// are routed back by that index. At most MaxOutstanding writes can be
// un-responded at any time.
//
// Optional feature: define UNCACHED_WR_TIMEOUT_EN to build a watchdog. It sets
// the sticky timeout_o flag when no B response arrives for TimeoutCycles-1
// cycles while writes are outstanding. Without the macro, timeout_o is tied 0.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     per-requester request handshake (ready is a grant pulse)
//   req_addr/data/strb/id_i packed per-requester payload, requester 0 in the LSBs
//   rsp_valid_o/ready_i     per-requester write response handshake
//   rsp_resp_o, rsp_id_o    shared BRESP and requester-local ID
//   aw_*, w_*, b_*          downstream AXI4 write channels (single beat, w_last_o = 1)
//   outstanding_o           current in-flight write count
//   timeout_o               sticky watchdog flag
module cva6_uncached_wr_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned InIdWidth      = 4,
  parameter int unsigned OutIdWidth     = InIdWidth + $clog2(NumReq),
  parameter int unsigned MaxOutstanding = 7,
  parameter int unsigned TimeoutCycles  = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]       req_addr_i,
  input  logic [NumReq*DataWidth-1:0]       req_data_i,
  input  logic [NumReq*(DataWidth/8)-1:0]   req_strb_i,
  input  logic [NumReq*InIdWidth-1:0]       req_id_i,
  output logic [NumReq-1:0]                 rsp_valid_o,
  input  logic [NumReq-1:0]                 rsp_ready_i,
  output logic [1:0]                        rsp_resp_o,
  output logic [InIdWidth-1:0]              rsp_id_o,
  output logic                              aw_valid_o,
  input  logic                              aw_ready_i,
  output logic [AddrWidth-1:0]              aw_addr_o,
  output logic [OutIdWidth-1:0]             aw_id_o,
  output logic                              w_valid_o,
  input  logic                              w_ready_i,
  output logic [DataWidth-1:0]              w_data_o,
  output logic [DataWidth/8-1:0]            w_strb_o,
  output logic                              w_last_o,
  input  logic                              b_valid_i,
  output logic                              b_ready_o,
  input  logic [OutIdWidth-1:0]             b_id_i,
  input  logic [1:0]                        b_resp_i,
  output logic [7:0]                        outstanding_o,
  output logic                              timeout_o
);

  localparam int unsigned IdxWidth  = $clog2(NumReq);
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                r_state;
  logic [IdxWidth-1:0]   r_rr_ptr;    // first index to consider on the next grant
  logic [7:0]            r_count;

  logic                  w_grant_found;
  logic [IdxWidth-1:0]   w_grant_idx;
  logic                  w_grant;
  logic [IdxWidth-1:0]   w_rr_next;
  logic [AddrWidth-1:0]  w_sel_addr;
  logic [DataWidth-1:0]  w_sel_data;
  logic [StrbWidth-1:0]  w_sel_strb;
  logic [InIdWidth-1:0]  w_sel_id;
  logic [IdxWidth-1:0]   w_b_idx;
  logic                  w_b_ready;
  logic                  w_b_hs;

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      if (!w_grant_found && req_valid_i[(int'(r_rr_ptr) + k) % int'(NumReq)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = IdxWidth'((int'(r_rr_ptr) + k) % int'(NumReq));
      end
    end
  end

  // A B handshake in the same cycle does not free a slot for this cycle's grant.
  assign w_grant = !rst_i && (r_state == StIdle) && w_grant_found &&
                   (r_count < 8'(MaxOutstanding));

  assign w_rr_next = (w_grant_idx == IdxWidth'(NumReq - 1)) ? '0
                                                             : w_grant_idx + IdxWidth'(1);

  always_comb begin
    req_ready_o = '0;
    if (w_grant) begin
      req_ready_o[w_grant_idx] = 1'b1;
    end
  end

  // Payload of the winning requester.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_strb = '0;
    w_sel_id   = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (w_grant_idx == IdxWidth'(i)) begin
        w_sel_addr = req_addr_i[i*AddrWidth +: AddrWidth];
        w_sel_data = req_data_i[i*DataWidth +: DataWidth];
        w_sel_strb = req_strb_i[i*StrbWidth +: StrbWidth];
        w_sel_id   = req_id_i[i*InIdWidth +: InIdWidth];
      end
    end
  end

  // Request FSM. AW and W valids are registered and drop independently on
  // their own handshakes; the FSM leaves SEND once both have completed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      aw_valid_o <= 1'b0;
      w_valid_o  <= 1'b0;
      aw_addr_o  <= '0;
      aw_id_o    <= '0;
      w_data_o   <= '0;
      w_strb_o   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_state    <= StSend;
            r_rr_ptr   <= w_rr_next;
            aw_valid_o <= 1'b1;
            w_valid_o  <= 1'b1;
            aw_addr_o  <= w_sel_addr;
            aw_id_o    <= {w_grant_idx, w_sel_id};
            w_data_o   <= w_sel_data;
            w_strb_o   <= w_sel_strb;
          end
        end
        StSend: begin
          if (aw_ready_i) begin
            aw_valid_o <= 1'b0;
          end
          if (w_ready_i) begin
            w_valid_o <= 1'b0;
          end
          if ((!aw_valid_o || aw_ready_i) && (!w_valid_o || w_ready_i)) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_last_o = 1'b1;

  // Response routing. An index with no matching requester is accepted and dropped.
  assign w_b_idx = b_id_i[OutIdWidth-1 -: IdxWidth];

  always_comb begin
    rsp_valid_o = '0;
    w_b_ready   = 1'b1;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (w_b_idx == IdxWidth'(i)) begin
        rsp_valid_o[i] = b_valid_i;
        w_b_ready      = rsp_ready_i[i];
      end
    end
  end

  assign b_ready_o  = w_b_ready;
  assign rsp_id_o   = b_id_i[InIdWidth-1:0];
  assign rsp_resp_o = b_resp_i;
  assign w_b_hs     = b_valid_i && w_b_ready;

  // In-flight counter. A grant and a B handshake in the same cycle cancel out.
  // The counter saturates at zero on a B handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (w_grant && !w_b_hs) begin
      r_count <= r_count + 8'd1;
    end else if (!w_grant && w_b_hs && (r_count != '0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign outstanding_o = r_count;

`ifdef UNCACHED_WR_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(TimeoutCycles) + 1;

  logic [WdWidth-1:0] r_wd_cnt;
  logic [WdWidth-1:0] w_wd_next;
  logic               w_wd_clr;
  logic               r_timeout;

  assign w_wd_clr = w_b_hs || (r_count == '0);

  always_comb begin
    w_wd_next = r_wd_cnt;
    if (w_wd_clr) begin
      w_wd_next = '0;
    end else if (r_wd_cnt != WdWidth'(TimeoutCycles - 1)) begin
      w_wd_next = r_wd_cnt + WdWidth'(1);
    end
  end

  // The flag is sticky until reset; it has no effect on flow control.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_next;
      if (!w_wd_clr && (w_wd_next == WdWidth'(TimeoutCycles - 1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cva6_uncached_wr_arbiter.sv
// Self-checking bench for cva6_uncached_wr_arbiter. Runs directed scenarios,
// then random stimulus, all compared every cycle against a transaction-level
// reference model.
module tb_cva6_uncached_wr_arbiter;

  localparam int NR   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int IIW  = 4;
  localparam int IXW  = 2;
  localparam int OIW  = IIW + IXW;
  localparam int MAXO = 7;
  localparam int TC   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [AW-1:0]     t_addr [NR];
  logic [DW-1:0]     t_data [NR];
  logic [SW-1:0]     t_strb [NR];
  logic [IIW-1:0]    t_id   [NR];
  logic [NR*AW-1:0]  addr_bus;
  logic [NR*DW-1:0]  data_bus;
  logic [NR*SW-1:0]  strb_bus;
  logic [NR*IIW-1:0] id_bus;
  logic [1:0]        rsp_resp;
  logic [IIW-1:0]    rsp_id;
  logic              aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [AW-1:0]     aw_addr;
  logic [OIW-1:0]    aw_id, b_id;
  logic [DW-1:0]     w_data;
  logic [SW-1:0]     w_strb;
  logic [1:0]        b_resp;
  logic [7:0]        outstanding;
  logic              timeout;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign addr_bus[g*AW +: AW]   = t_addr[g];
    assign data_bus[g*DW +: DW]   = t_data[g];
    assign strb_bus[g*SW +: SW]   = t_strb[g];
    assign id_bus[g*IIW +: IIW]   = t_id[g];
  end

  cva6_uncached_wr_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .InIdWidth(IIW),
    .OutIdWidth(OIW), .MaxOutstanding(MAXO), .TimeoutCycles(TC)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(addr_bus), .req_data_i(data_bus), .req_strb_i(strb_bus), .req_id_i(id_bus),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_resp_o(rsp_resp), .rsp_id_o(rsp_id),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .w_last_o(w_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_id_i(b_id), .b_resp_i(b_resp),
    .outstanding_o(outstanding), .timeout_o(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one write in flight at a time, with pending AW/W flags.
  bit             m_busy, m_awp, m_wp, m_to;
  int             m_next, m_count, m_wd;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_data;
  logic [SW-1:0]  m_strb;
  logic [OIW-1:0] m_id;
  int             obs_q[$];

  task automatic model_reset();
    m_busy = 0; m_awp = 0; m_wp = 0; m_to = 0;
    m_next = 0; m_count = 0; m_wd = 0;
    m_addr = '0; m_data = '0; m_strb = '0; m_id = '0;
  endtask

  // Called just after a falling edge with this cycle's inputs applied. Checks
  // all outputs, advances the model, and returns at the next falling edge.
  task automatic tick();
    bit            grant, bhs, clr;
    int            gi, bi, c;
    logic [NR-1:0] e_ready, e_rsp;
    logic          e_bready;
    #1;
    grant = 0; gi = 0;
    if (!rst && !m_busy && m_count < MAXO) begin
      for (int k = 0; k < NR; k++) begin
        c = (m_next + k) % NR;
        if (!grant && req_valid[c]) begin grant = 1; gi = c; end
      end
    end
    e_ready = '0;
    if (grant) e_ready[gi] = 1'b1;
    bi = int'(b_id[OIW-1 -: IXW]);
    e_rsp = '0; e_bready = 1'b1;
    if (bi < NR) begin e_rsp[bi] = b_valid; e_bready = rsp_ready[bi]; end

    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    check("b_ready", 64'(b_ready), 64'(e_bready));
    check("rsp_id", 64'(rsp_id), 64'(b_id[IIW-1:0]));
    check("rsp_resp", 64'(rsp_resp), 64'(b_resp));
    check("aw_valid", 64'(aw_valid), 64'(m_awp));
    check("w_valid", 64'(w_valid), 64'(m_wp));
    check("aw_addr", 64'(aw_addr), 64'(m_addr));
    check("aw_id", 64'(aw_id), 64'(m_id));
    check("w_data", 64'(w_data), 64'(m_data));
    check("w_strb", 64'(w_strb), 64'(m_strb));
    check("w_last", 64'(w_last), 64'd1);
    check("outstanding", 64'(outstanding), 64'(m_count));
    check("timeout", 64'(timeout), 64'(m_to));
    for (int i = 0; i < NR; i++) if (req_ready[i]) obs_q.push_back(i);

    bhs = b_valid && e_bready;
    if (rst) begin
      model_reset();
    end else begin
`ifdef UNCACHED_WR_TIMEOUT_EN
      clr = bhs || (m_count == 0);
      if (clr) m_wd = 0;
      else if (m_wd != TC - 1) m_wd++;
      if (!clr && m_wd == TC - 1) m_to = 1;
`else
      clr = 0;
`endif
      if (m_busy) begin
        if (aw_ready) m_awp = 0;
        if (w_ready) m_wp = 0;
        if (!m_awp && !m_wp) m_busy = 0;
      end
      if (grant) begin
        m_busy = 1; m_awp = 1; m_wp = 1;
        m_addr = t_addr[gi]; m_data = t_data[gi]; m_strb = t_strb[gi];
        m_id   = {IXW'(gi), t_id[gi]};
        m_next = (gi + 1) % NR;
      end
      if (grant && !bhs) m_count++;
      else if (!grant && bhs && m_count > 0) m_count--;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; b_valid = 1'b0; b_id = '0; b_resp = '0;
    aw_ready = 1'b1; w_ready = 1'b1; rsp_ready = '1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0; b_valid = 1'b1; b_id = '0; rsp_ready = '1;
    aw_ready = 1'b1; w_ready = 1'b1;
    while (m_count > 0 && n < 20) begin tick(); n++; end
    b_valid = 1'b0;
    check("drain_outstanding", 64'(outstanding), 64'd0);
  endtask

  logic [AW-1:0] held_addr;
  int            g0, g1;
  int            tw;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      t_addr[i] = '0; t_data[i] = '0; t_strb[i] = '0; t_id[i] = '0;
    end
    idle_inputs();
    model_reset();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Single write from requester 0.
    t_addr[0] = 32'h1A10_0000; t_data[0] = 32'hDEAD_BEEF; t_strb[0] = 4'hF; t_id[0] = 4'd3;
    req_valid = 3'b001;
    #1 check("t1_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = '0;
    check("t1_aw_valid", 64'(aw_valid), 64'd1);
    check("t1_aw_id", 64'(aw_id), 64'h03);
    check("t1_aw_addr", 64'(aw_addr), 64'h1A10_0000);
    check("t1_w_data", 64'(w_data), 64'hDEAD_BEEF);
    tick();
    check("t1_aw_done", 64'(aw_valid), 64'd0);
    tick();
    b_valid = 1'b1; b_id = 6'h03; b_resp = 2'd0;
    #1 check("t1_rsp_valid", 64'(rsp_valid), 64'b001);
    check("t1_rsp_id", 64'(rsp_id), 64'd3);
    tick();
    b_valid = 1'b0;
    check("t1_outstanding", 64'(outstanding), 64'd0);

    // Two continuous requesters alternate; B drains the count every cycle.
    t_id[1] = 4'd9;
    obs_q.delete();
    req_valid = 3'b011; b_valid = 1'b1; b_id = '0;
    repeat (20) tick();
    req_valid = '0; b_valid = 1'b0;
    check("t2_grants", 64'(obs_q.size()), 64'd10);
    g0 = 0; g1 = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i] == 0) g0++;
      if (obs_q[i] == 1) g1++;
      if (i > 0) check("t2_alternate", 64'(obs_q[i]), 64'(1 - obs_q[i-1]));
    end
    check("t2_share0", 64'(g0), 64'd5);
    check("t2_share1", 64'(g1), 64'd5);
    drain();

    // AW back-pressured for 5 cycles, W completes first.
    t_addr[0] = 32'hCAFE_0040;
    req_valid = 3'b001; aw_ready = 1'b0; w_ready = 1'b1;
    tick();
    req_valid = '0;
    held_addr = aw_addr;
    check("t3_held_addr", 64'(held_addr), 64'hCAFE_0040);
    repeat (5) begin
      tick();
      check("t3_aw_hold", 64'(aw_valid), 64'd1);
      check("t3_aw_stable", 64'(aw_addr), 64'(held_addr));
      check("t3_w_done", 64'(w_valid), 64'd0);
    end
    req_valid = 3'b001;
    #1 check("t3_no_grant_in_send", 64'(req_ready), 64'd0);
    req_valid = '0;
    aw_ready = 1'b1;
    tick();
    check("t3_aw_done", 64'(aw_valid), 64'd0);
    drain();

    // Fill to the outstanding limit.
    req_valid = 3'b001; b_valid = 1'b0;
    repeat (16) tick();
    check("t4_full", 64'(outstanding), 64'd7);
    #1 check("t4_no_grant", 64'(req_ready), 64'd0);
    b_valid = 1'b1; b_id = '0;
    #1 check("t4_no_grant_with_b", 64'(req_ready), 64'd0);
    tick();
    b_valid = 1'b0;
    #1 check("t4_grant_after_b", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check("t4_refull", 64'(outstanding), 64'd7);
    tick();

    // Grant and B in the same cycle at count 3.
    b_valid = 1'b1;
    repeat (4) tick();
    b_valid = 1'b0;
    check("t5_count3", 64'(outstanding), 64'd3);
    req_valid = 3'b001; b_valid = 1'b1;
    #1 check("t5_grant", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0; b_valid = 1'b0;
    check("t5_same_cycle", 64'(outstanding), 64'd3);
    tick();
    drain();

    // Response with an index beyond NumReq is accepted and dropped.
    b_valid = 1'b1; b_id = {2'd3, 4'h5}; rsp_ready = '0;
    #1 check("t6_b_ready", 64'(b_ready), 64'd1);
    check("t6_no_rsp", 64'(rsp_valid), 64'd0);
    tick();
    b_valid = 1'b0; rsp_ready = '1;
    check("t6_outstanding", 64'(outstanding), 64'd0);

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        t_addr[i] = $urandom; t_data[i] = $urandom;
        t_strb[i] = SW'($urandom); t_id[i] = IIW'($urandom);
      end
      aw_ready  = ($urandom_range(0, 2) != 0);
      w_ready   = ($urandom_range(0, 2) != 0);
      b_valid   = ($urandom_range(0, 1) != 0);
      b_id      = {IXW'($urandom_range(0, NR)), IIW'($urandom)};
      b_resp    = 2'($urandom);
      rsp_ready = NR'($urandom);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    drain();

`ifdef UNCACHED_WR_TIMEOUT_EN
    // One write, no response: the watchdog fires and stays set.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    tw = 0;
    while (!timeout && tw < 40) begin tick(); tw++; end
    check("t7_timeout_set", 64'(timeout), 64'd1);
    b_valid = 1'b1; b_id = '0;
    tick();
    b_valid = 1'b0;
    tick();
    check("t7_timeout_sticky", 64'(timeout), 64'd1);
`else
    tw = 0;
    check("t7_timeout_tied", 64'(timeout), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
